// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if
//   Bundles the ID-stage hazard query and the hazard/forwarding decisions
//   exchanged between the pipeline (master) and hazard_fwd_unit (slave).
// Signals
//   enable        pipeline advance; 0 freezes the unit
//   id_rs/id_rt   source registers of the instruction in ID
//   id_use_rs/rt  ID instruction actually reads rs / rt
//   id_reg_write  ID instruction writes a register
//   id_mem_read   ID instruction is a load
//   id_waddr      destination register of the ID instruction
//   br_taken      taken branch/jump resolved this cycle
//   stall, flush  hazard controls (combinational)
//   fwd_a_sel/b   registered EX operand source selects
//   stall_cnt, flush_cnt  saturating event counters
interface hazard_fwd_unit_if #(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 32
);
  logic              enable;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [ADDR_W-1:0] id_waddr;
  logic              br_taken;
  logic              stall;
  logic              flush;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output enable, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write,
           id_mem_read, id_waddr, br_taken,
    input  stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  enable, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write,
           id_mem_read, id_waddr, br_taken,
    output stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard and forwarding controller sitting beside ID. Tracks in-flight
//   destination registers in a shifting scoreboard, raises load-use stalls
//   and branch flushes, and registers the EX operand forwarding selects.
// Ports
//   clk     rising-edge clock
//   arst_n  asynchronous active-low reset
//   bus     hazard_fwd_unit_if.slave (ID query in, stall/flush/selects/counters out)
module hazard_fwd_unit #(
  parameter int DEPTH         = 3,
  parameter int ADDR_W        = 5,
  parameter int RESOLVE_STAGE = 2,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  hazard_fwd_unit_if.slave  bus
);
  localparam int SEL_W = $clog2(DEPTH);
  // The WB entry can never produce a forward (write-through register file)
  // and nothing downstream reads it, so only entries EX..DEPTH-2 are stored.
  localparam int NE = DEPTH - 1;

  logic [NE-1:0]     vld_q, vld_d;
  logic [NE-1:0]     rw_q, rw_d;
  logic [ADDR_W-1:0] wa_q [NE];
  logic [ADDR_W-1:0] wa_d [NE];
  // Only the EX entry's load flag is ever consulted.
  logic              ld0_q, ld0_d;
  logic [SEL_W-1:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [SEL_W-1:0]  match_a, match_b;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              load_use, stall, flush, take;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int j = NE - 1; j >= 0; j--) begin
      if (vld_q[j] && rw_q[j] && (wa_q[j] != '0)) begin
        if (bus.id_use_rs && (wa_q[j] == bus.id_rs)) match_a = SEL_W'(j + 1);
        if (bus.id_use_rt && (wa_q[j] == bus.id_rt)) match_b = SEL_W'(j + 1);
      end
    end
  end

  // A select of 1 means the EX entry is the youngest match.
  assign load_use = ld0_q && ((match_a == SEL_W'(1)) || (match_b == SEL_W'(1)));
  assign flush    = bus.br_taken && bus.enable;
  assign stall    = load_use && bus.enable && !flush;
  assign take     = !stall && !flush;

  always_comb begin
    vld_d       = vld_q;
    rw_d        = rw_q;
    wa_d        = wa_q;
    ld0_d       = ld0_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.enable) begin
      for (int j = NE - 1; j >= 1; j--) begin
        vld_d[j] = vld_q[j-1];
        rw_d[j]  = rw_q[j-1];
        wa_d[j]  = wa_q[j-1];
      end
      vld_d[0] = take;
      rw_d[0]  = bus.id_reg_write;
      wa_d[0]  = bus.id_waddr;
      ld0_d    = bus.id_mem_read;
      // Instructions behind the resolving branch are squashed.
      if (flush) begin
        for (int j = 1; j < RESOLVE_STAGE; j++) vld_d[j] = 1'b0;
      end
      sel_a_d = take ? match_a : '0;
      sel_b_d = take ? match_b : '0;
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_q <= '0;
      rw_q  <= '0;
      for (int j = 0; j < NE; j++) wa_q[j] <= '0;
      ld0_q       <= 1'b0;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      rw_q        <= rw_d;
      wa_q        <= wa_d;
      ld0_q       <= ld0_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.fwd_a_sel = sel_a_q;
  assign bus.fwd_b_sel = sel_b_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
//   Directed bench. Instance A uses default parameters; instance B uses
//   DEPTH=5, RESOLVE_STAGE=3, CNT_W=3 so select scaling and counter
//   saturation are reachable. Both see identical stimulus.
module tb_hazard_fwd_unit;
  logic       clk = 1'b0;
  logic       arst_n;
  logic       enable;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read, br_taken;
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.ADDR_W(5), .SEL_W(2), .CNT_W(32)) ifa ();
  hazard_fwd_unit_if #(.ADDR_W(5), .SEL_W(3), .CNT_W(3))  ifb ();

  assign ifa.enable = enable;        assign ifb.enable = enable;
  assign ifa.id_rs = id_rs;          assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;          assign ifb.id_rt = id_rt;
  assign ifa.id_use_rs = id_use_rs;  assign ifb.id_use_rs = id_use_rs;
  assign ifa.id_use_rt = id_use_rt;  assign ifb.id_use_rt = id_use_rt;
  assign ifa.id_reg_write = id_reg_write; assign ifb.id_reg_write = id_reg_write;
  assign ifa.id_mem_read = id_mem_read;   assign ifb.id_mem_read = id_mem_read;
  assign ifa.id_waddr = id_waddr;    assign ifb.id_waddr = id_waddr;
  assign ifa.br_taken = br_taken;    assign ifb.br_taken = br_taken;

  hazard_fwd_unit dut_a (.clk(clk), .arst_n(arst_n), .bus(ifa));
  hazard_fwd_unit #(.DEPTH(5), .ADDR_W(5), .RESOLVE_STAGE(3), .CNT_W(3))
    dut_b (.clk(clk), .arst_n(arst_n), .bus(ifb));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_id(input int rs, input int rt, input int urs, input int urt,
                        input int wr, input int mr, input int wa);
    id_rs        = 5'(rs);
    id_rt        = 5'(rt);
    id_use_rs    = (urs != 0);
    id_use_rt    = (urt != 0);
    id_reg_write = (wr != 0);
    id_mem_read  = (mr != 0);
    id_waddr     = 5'(wa);
  endtask

  task automatic nop_id();
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) begin
      nop_id();
      step();
    end
  endtask

  // add r3,r1,r2 ; <gaps> nops ; sub r4,r3,r2 -- leaves sub in EX
  task automatic gap_seq(input int gaps);
    set_id(1, 2, 1, 1, 1, 0, 3);
    step();
    for (int i = 0; i < gaps; i++) begin
      nop_id();
      step();
    end
    set_id(3, 2, 1, 1, 1, 0, 4);
    step();
  endtask

  initial begin
    arst_n   = 1'b0;
    enable   = 1'b1;
    br_taken = 1'b0;
    nop_id();
    #12;
    chk("rst_stall", 64'(ifa.stall), 64'd0);
    chk("rst_flush", 64'(ifa.flush), 64'd0);
    chk("rst_sel_a", 64'(ifa.fwd_a_sel), 64'd0);
    chk("rst_sel_b", 64'(ifa.fwd_b_sel), 64'd0);
    chk("rst_stall_cnt", 64'(ifa.stall_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(ifa.flush_cnt), 64'd0);
    arst_n = 1'b1;
    step();

    // back-to-back dependency
    set_id(1, 2, 1, 1, 1, 0, 3);
    step();
    set_id(3, 2, 1, 1, 1, 0, 4);
    #1;
    chk("b2b_no_stall", 64'(ifa.stall), 64'd0);
    step();
    chk("b2b_sel_a", 64'(ifa.fwd_a_sel), 64'd1);
    chk("b2b_sel_b", 64'(ifa.fwd_b_sel), 64'd0);
    chk("b2b_sel_a_d5", 64'(ifb.fwd_a_sel), 64'd1);
    drain();

    // two writers of r3: youngest wins
    set_id(1, 2, 1, 1, 1, 0, 3); step();
    set_id(1, 1, 1, 0, 1, 0, 3); step();
    set_id(3, 2, 1, 1, 1, 0, 4); step();
    chk("youngest_wins", 64'(ifa.fwd_a_sel), 64'd1);
    drain();

    // rt forwarding
    set_id(1, 2, 1, 1, 1, 0, 7); step();
    set_id(1, 7, 1, 1, 1, 0, 8); step();
    chk("rt_sel_b", 64'(ifa.fwd_b_sel), 64'd1);
    chk("rt_sel_a", 64'(ifa.fwd_a_sel), 64'd0);
    drain();

    // r0 never matches
    set_id(1, 2, 1, 1, 1, 0, 0); step();
    set_id(0, 0, 1, 1, 1, 0, 4); step();
    chk("r0_sel_a", 64'(ifa.fwd_a_sel), 64'd0);
    drain();

    // unused source never matches
    set_id(1, 2, 1, 1, 1, 0, 3); step();
    set_id(3, 3, 0, 0, 1, 0, 4); step();
    chk("unused_sel_a", 64'(ifa.fwd_a_sel), 64'd0);
    chk("unused_sel_b", 64'(ifa.fwd_b_sel), 64'd0);
    drain();

    gap_seq(1);
    chk("gap1_sel_a", 64'(ifa.fwd_a_sel), 64'd2);
    chk("gap1_sel_a_d5", 64'(ifb.fwd_a_sel), 64'd2);
    drain();
    gap_seq(2);
    chk("gap2_sel_a", 64'(ifa.fwd_a_sel), 64'd0);
    chk("gap2_sel_a_d5", 64'(ifb.fwd_a_sel), 64'd3);
    drain();
    gap_seq(3);
    chk("gap3_sel_a_d5", 64'(ifb.fwd_a_sel), 64'd4);
    drain();

    // load-use: lw r5 ; add r6,r5
    set_id(1, 0, 1, 0, 1, 1, 5); step();
    set_id(5, 2, 1, 1, 1, 0, 6);
    #1;
    chk("lu_stall", 64'(ifa.stall), 64'd1);
    chk("lu_stall_d5", 64'(ifb.stall), 64'd1);
    step();
    chk("lu_bubble_sel", 64'(ifa.fwd_a_sel), 64'd0);
    chk("lu_one_cycle", 64'(ifa.stall), 64'd0);
    chk("lu_stall_cnt", 64'(ifa.stall_cnt), 64'd1);
    step();
    chk("lu_after_sel", 64'(ifa.fwd_a_sel), 64'd2);
    drain();

    // flush on the same cycle as a load-use
    set_id(1, 0, 1, 0, 1, 1, 5); step();
    set_id(5, 2, 1, 1, 1, 0, 6);
    br_taken = 1'b1;
    #1;
    chk("fl_flush", 64'(ifa.flush), 64'd1);
    chk("fl_no_stall", 64'(ifa.stall), 64'd0);
    step();
    br_taken = 1'b0;
    chk("fl_flush_cnt", 64'(ifa.flush_cnt), 64'd1);
    chk("fl_stall_cnt", 64'(ifa.stall_cnt), 64'd1);
    chk("fl_sel_a", 64'(ifa.fwd_a_sel), 64'd0);
    #1;
    chk("fl_squashed_stall", 64'(ifa.stall), 64'd0);
    step();
    chk("fl_squashed_sel", 64'(ifa.fwd_a_sel), 64'd0);
    chk("fl_squashed_sel_d5", 64'(ifb.fwd_a_sel), 64'd0);
    chk("fl_flush_cnt_d5", 64'(ifb.flush_cnt), 64'd1);
    drain();

    // freeze with a pending load-use
    set_id(1, 2, 1, 1, 1, 0, 3); step();
    set_id(3, 0, 1, 0, 1, 1, 5); step();
    chk("frz_lw_sel", 64'(ifa.fwd_a_sel), 64'd1);
    enable = 1'b0;
    set_id(5, 2, 1, 1, 1, 0, 6);
    #1;
    chk("frz_no_stall", 64'(ifa.stall), 64'd0);
    step();
    step();
    chk("frz_sel_hold", 64'(ifa.fwd_a_sel), 64'd1);
    chk("frz_cnt_hold", 64'(ifa.stall_cnt), 64'd1);
    enable = 1'b1;
    #1;
    chk("frz_release_stall", 64'(ifa.stall), 64'd1);
    step();
    chk("frz_stall_cnt", 64'(ifa.stall_cnt), 64'd2);
    drain();

    // seven more load-use stalls: B saturates at 7
    for (int k = 0; k < 7; k++) begin
      set_id(1, 0, 1, 0, 1, 1, 5); step();
      set_id(5, 2, 1, 1, 1, 0, 6); step();
      step();
    end
    chk("sat_cnt_a", 64'(ifa.stall_cnt), 64'd9);
    chk("sat_cnt_b", 64'(ifb.stall_cnt), 64'd7);
    drain();

    // async reset mid-stream with three valid entries
    set_id(1, 2, 1, 1, 1, 0, 3); step();
    set_id(1, 2, 1, 1, 1, 0, 4); step();
    set_id(1, 0, 1, 0, 1, 1, 5); step();
    set_id(5, 2, 1, 1, 1, 0, 6);
    #1;
    chk("pre_rst_stall", 64'(ifa.stall), 64'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(ifa.stall), 64'd0);
    chk("mid_rst_sel_a", 64'(ifa.fwd_a_sel), 64'd0);
    chk("mid_rst_stall_cnt", 64'(ifa.stall_cnt), 64'd0);
    chk("mid_rst_flush_cnt", 64'(ifa.flush_cnt), 64'd0);
    chk("mid_rst_stall_cnt_d5", 64'(ifb.stall_cnt), 64'd0);
    #2;
    arst_n = 1'b1;
    #1;
    chk("post_rst_stall", 64'(ifa.stall), 64'd0);
    step();
    chk("post_rst_sel_a", 64'(ifa.fwd_a_sel), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
